// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller and its prediction FIFO.
package branch_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] UPD_NONE = 2'b00;
  localparam logic [1:0] UPD_COND = 2'b01;

  // Packed width of one queued prediction {taken, target, fallthru}.
  function automatic int entry_w(input int addr_w);
    return 1 + 2 * addr_w;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_pred_fifo.sv
// In-order queue of outstanding predictions; clear wins over push.
module pred_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        din,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   occ;

  // The extra pointer MSB separates full from empty when the index bits match.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign occ   = wr_ptr - rd_ptr;
  assign count = CW'(occ);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Matches in-order branch resolutions against queued predictions, trains the predictor and flushes on mispredict.
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_h,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [ADDR_W-1:0]          pred_target,
  input  logic [ADDR_W-1:0]          pred_fallthru,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_act_taken,
  output logic                       upd_pred_taken,
  output logic [1:0]                 upd_cond,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
  output logic                       res_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fallthru;
  } pred_entry_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [CW-1:0]     count;
  pred_entry_t       head;
  pred_entry_t       din;
  logic              ready, push, resolve, mispred, empty_res;
  logic              upd_v_q, act_q, pt_q, redir_v_q, err_q;
  logic [ADDR_W-1:0] redir_pc_q;

  assign ready     = (state_q == RUN) && (count < CW'(DEPTH)) && !rst_h;
  assign push      = pred_valid && ready;
  assign resolve   = (state_q == RUN) && res_valid && (count != '0) && !rst_h;
  assign empty_res = (state_q == RUN) && res_valid && (count == '0) && !rst_h;
  assign mispred   = resolve && (res_taken != head.taken);
  assign din       = '{taken: pred_taken, target: pred_target, fallthru: pred_fallthru};

  // A mispredict discards everything, including a same-cycle push.
  pred_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (pred_entry_t)
  ) u_fifo (
    .clk   (clk),
    .push  (push),
    .pop   (resolve && !mispred),
    .clear (rst_h || mispred),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (mispred) begin
          state_d = FLUSH;
          fcnt_d  = FW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = RUN;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      state_q    <= RUN;
      fcnt_q     <= '0;
      upd_v_q    <= 1'b0;
      act_q      <= 1'b0;
      pt_q       <= 1'b0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      upd_v_q    <= resolve;
      act_q      <= resolve && res_taken;
      pt_q       <= resolve && head.taken;
      redir_v_q  <= mispred;
      redir_pc_q <= mispred ? (res_taken ? head.target : head.fallthru) : '0;
      err_q      <= err_q || empty_res;
    end
  end

  // Reset forces every output low in the same cycle it is asserted.
  assign pred_ready     = ready;
  assign upd_cond       = (upd_v_q && !rst_h) ? UPD_COND : UPD_NONE;
  assign upd_act_taken  = act_q && !rst_h;
  assign upd_pred_taken = pt_q && !rst_h;
  assign flush          = (state_q == FLUSH) && !rst_h;
  assign redirect_valid = redir_v_q && !rst_h;
  assign redirect_pc    = rst_h ? '0 : redir_pc_q;
  assign pending_cnt    = rst_h ? '0 : count;
  assign res_err        = err_q && !rst_h;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a queue-based reference model checked every cycle.
module tb_branch_resolve_ctrl;

  localparam int DEPTH        = 4;
  localparam int ADDR_W       = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CW           = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_h;
  logic              pred_valid, pred_taken;
  logic [ADDR_W-1:0] pred_target, pred_fallthru;
  logic              pred_ready;
  logic              res_valid, res_taken;
  logic              upd_act_taken, upd_pred_taken;
  logic [1:0]        upd_cond;
  logic              flush, redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CW-1:0]     pending_cnt;
  logic              res_err;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_h          (rst_h),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_fallthru  (pred_fallthru),
    .pred_ready     (pred_ready),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .upd_act_taken  (upd_act_taken),
    .upd_pred_taken (upd_pred_taken),
    .upd_cond       (upd_cond),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pending_cnt    (pending_cnt),
    .res_err        (res_err)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fall;
  } m_ent_t;

  m_ent_t            exp_q[$];
  int                flush_left = 0;
  logic              m_err = 1'b0, m_upd = 1'b0, m_act = 1'b0, m_pt = 1'b0, m_redir = 1'b0;
  logic [ADDR_W-1:0] m_pc = '0;

  always @(posedge clk) begin
    logic   mis;
    logic   rdy;
    m_ent_t h;
    if (rst_h) begin
      exp_q.delete();
      flush_left = 0;
      m_err = 0; m_upd = 0; m_act = 0; m_pt = 0; m_redir = 0; m_pc = '0;
    end else begin
      mis = 0;
      rdy = (flush_left == 0) && (exp_q.size() < DEPTH);
      m_upd = 0; m_act = 0; m_pt = 0; m_redir = 0;
      if (flush_left == 0 && res_valid) begin
        if (exp_q.size() == 0) begin
          m_err = 1;
        end else begin
          h = exp_q.pop_front();
          m_upd = 1;
          m_act = res_taken;
          m_pt  = h.taken;
          if (res_taken != h.taken) begin
            mis = 1;
            m_redir = 1;
            m_pc = res_taken ? h.target : h.fall;
            exp_q.delete();
          end
        end
      end
      if (flush_left > 0) flush_left--;
      if (mis) flush_left = FLUSH_CYCLES;
      if (rdy && pred_valid && !mis) exp_q.push_back('{pred_taken, pred_target, pred_fallthru});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (rst_h) begin
      check("rst_pred_ready", 64'(pred_ready), 0);
      check("rst_upd_cond", 64'(upd_cond), 0);
      check("rst_upd_act", 64'(upd_act_taken), 0);
      check("rst_upd_pred", 64'(upd_pred_taken), 0);
      check("rst_flush", 64'(flush), 0);
      check("rst_redirect_valid", 64'(redirect_valid), 0);
      check("rst_redirect_pc", 64'(redirect_pc), 0);
      check("rst_pending_cnt", 64'(pending_cnt), 0);
      check("rst_res_err", 64'(res_err), 0);
    end else begin
      check("pred_ready", 64'(pred_ready), 64'((flush_left == 0) && (exp_q.size() < DEPTH)));
      check("upd_cond", 64'(upd_cond), m_upd ? 64'd1 : 64'd0);
      check("upd_act_taken", 64'(upd_act_taken), 64'(m_act));
      check("upd_pred_taken", 64'(upd_pred_taken), 64'(m_pt));
      check("flush", 64'(flush), 64'(flush_left > 0));
      check("redirect_valid", 64'(redirect_valid), 64'(m_redir));
      if (m_redir) check("redirect_pc", 64'(redirect_pc), 64'(m_pc));
      check("pending_cnt", 64'(pending_cnt), 64'(exp_q.size()));
      check("res_err", 64'(res_err), 64'(m_err));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 0; pred_taken = 0; pred_target = '0; pred_fallthru = '0;
    res_valid = 0; res_taken = 0;
  endtask

  task automatic set_pred(input logic t, input logic [ADDR_W-1:0] tgt, input logic [ADDR_W-1:0] ft);
    pred_valid = 1; pred_taken = t; pred_target = tgt; pred_fallthru = ft;
  endtask

  task automatic set_res(input logic t);
    res_valid = 1; res_taken = t;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] tk;

  initial begin
    rst_h = 1;
    idle();
    pred_valid = 1;
    repeat (3) cyc();
    check("reset_pred_ready", 64'(pred_ready), 0);
    check("reset_flush", 64'(flush), 0);
    check("reset_upd_cond", 64'(upd_cond), 0);
    rst_h = 0;
    idle();
    cyc();
    check("release_pred_ready", 64'(pred_ready), 1);
    check("release_pending", 64'(pending_cnt), 0);

    // Four correct predictions.
    tk = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      set_pred(tk[i], 32'h1000 + 32'(i * 16), 32'h0040 + 32'(i * 4));
      cyc();
    end
    idle();
    check("full_pending", 64'(pending_cnt), 4);
    check("full_ready", 64'(pred_ready), 0);
    for (int i = 0; i < 4; i++) begin
      set_res(tk[i]);
      cyc();
      check("correct_upd_cond", 64'(upd_cond), 1);
      check("correct_act", 64'(upd_act_taken), 64'(tk[i]));
      check("correct_pred", 64'(upd_pred_taken), 64'(tk[i]));
      check("correct_no_flush", 64'(flush), 0);
    end
    idle();
    cyc();
    check("correct_upd_drop", 64'(upd_cond), 0);
    check("correct_pending_end", 64'(pending_cnt), 0);

    // Mispredict: predicted not-taken, actually taken.
    set_pred(0, 32'h100, 32'h24); cyc();
    set_pred(1, 32'h200, 32'h28); cyc();
    idle();
    set_res(1);
    cyc();
    idle();
    check("mis_redirect_valid", 64'(redirect_valid), 1);
    check("mis_redirect_pc", 64'(redirect_pc), 64'h100);
    check("mis_act", 64'(upd_act_taken), 1);
    check("mis_pred", 64'(upd_pred_taken), 0);
    check("mis_flush1", 64'(flush), 1);
    check("mis_pending", 64'(pending_cnt), 0);
    check("mis_ready", 64'(pred_ready), 0);
    cyc();
    check("mis_flush2", 64'(flush), 1);
    check("mis_redirect_once", 64'(redirect_valid), 0);
    check("mis_ready2", 64'(pred_ready), 0);
    cyc();
    check("mis_flush_end", 64'(flush), 0);
    check("mis_ready_back", 64'(pred_ready), 1);

    // Push in the mispredict cycle, then a resolve during FLUSH.
    set_pred(1, 32'h300, 32'h2c); cyc();
    set_pred(0, 32'h400, 32'h30);
    set_res(0);
    cyc();
    idle();
    check("pushmis_redirect_pc", 64'(redirect_pc), 64'h2c);
    check("pushmis_pending", 64'(pending_cnt), 0);
    set_res(1);
    cyc();
    idle();
    check("flush_res_no_upd", 64'(upd_cond), 0);
    cyc();
    cyc();
    check("pushmis_pending_after", 64'(pending_cnt), 0);
    check("flush_res_no_err", 64'(res_err), 0);

    // Full queue with simultaneous resolve and push.
    tk = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      set_pred(tk[i], 32'h2000 + 32'(i * 16), 32'h0080 + 32'(i * 4));
      cyc();
    end
    set_pred(1, 32'h5000, 32'h5004);
    set_res(tk[0]);
    cyc();
    idle();
    check("fullpop_pending", 64'(pending_cnt), 3);
    check("fullpop_ready", 64'(pred_ready), 1);
    check("fullpop_upd", 64'(upd_cond), 1);
    for (int i = 1; i < 4; i++) begin
      set_res(tk[i]);
      cyc();
    end
    idle();
    cyc();
    check("fullpop_drained", 64'(pending_cnt), 0);

    // Empty-queue resolve and reset recovery.
    set_res(1);
    cyc();
    idle();
    check("empty_res_err", 64'(res_err), 1);
    check("empty_no_upd", 64'(upd_cond), 0);
    cyc();
    check("empty_err_sticky", 64'(res_err), 1);
    rst_h = 1;
    cyc();
    rst_h = 0;
    cyc();
    check("rst_clears_err", 64'(res_err), 0);

    // Reset in the middle of FLUSH.
    set_pred(1, 32'h600, 32'h34); cyc();
    idle();
    set_res(0);
    cyc();
    idle();
    check("midflush_flush_on", 64'(flush), 1);
    rst_h = 1;
    cyc();
    check("midflush_flush_off", 64'(flush), 0);
    check("midflush_redirect_off", 64'(redirect_valid), 0);
    rst_h = 0;
    cyc();
    check("midflush_ready", 64'(pred_ready), 1);
    check("midflush_pending", 64'(pending_cnt), 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
